// File: rtl/gpio_pad_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpio_pad_ctrl_pkg
// Brief    : Shared types and constants for the sky130 GPIO pad controller.
// Revision : 1.0 - initial release
// ============================================================================
package gpio_pad_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP   = 3'd0,
        ST_ENABLE  = 3'd1,
        ST_RELEASE = 3'd2,
        ST_IDLE    = 3'd3,
        ST_HOLD    = 3'd4,
        ST_SETTLE  = 3'd5
    } state_e;

    localparam logic [2:0] c_dm_reset = 3'b001;

    typedef struct packed {
        logic [2:0] dm;
        logic       inp_dis;
        logic       slow;
    } pad_cfg_t;

    localparam pad_cfg_t c_pad_cfg_reset = '{dm: c_dm_reset, inp_dis: 1'b1, slow: 1'b0};

endpackage
`default_nettype wire

// File: rtl/gpio_pad_ctrl_timer.sv
`default_nettype none
// ============================================================================
// Module   : gpio_pad_ctrl_timer
// Brief    : Loadable down-counter; o_done marks the final cycle of an interval.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_pad_ctrl_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count,
    output logic             o_done
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;
    assign o_done  = (count_q == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/gpio_pad_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gpio_pad_ctrl
// Brief    : Power-up sequencing and hold-protected configuration of GPIO pads.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_pad_ctrl
    import gpio_pad_ctrl_pkg::*;
#(
    parameter int NUM_PADS      = 8,
    parameter int PWRUP_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [((NUM_PADS > 1) ? $clog2(NUM_PADS) : 1)-1:0] cfg_idx,
    input  logic [2:0]            cfg_dm,
    input  logic                  cfg_inp_dis,
    input  logic                  cfg_slow,
    input  logic [NUM_PADS-1:0]   core_out,
    input  logic [NUM_PADS-1:0]   core_oe,
    output logic                  init_done,
    output logic [NUM_PADS-1:0]   pad_out,
    output logic [NUM_PADS-1:0]   pad_oe_n,
    output logic [3*NUM_PADS-1:0] pad_dm,
    output logic [NUM_PADS-1:0]   pad_inp_dis,
    output logic [NUM_PADS-1:0]   pad_slow,
    output logic [NUM_PADS-1:0]   pad_hld_h_n,
    output logic                  pad_enable_h,
    output logic                  pad_enable_inp_h
);

    localparam int IDX_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
    localparam int TMAX  = (PWRUP_CYCLES > SETTLE_CYCLES + 1) ? PWRUP_CYCLES : SETTLE_CYCLES + 1;
    localparam int TW    = $clog2(TMAX + 1);

    // SETTLE lasts one cycle longer than the hold window: the extra cycle is the release.
    localparam logic [TW-1:0] c_pwrup_load   = TW'(PWRUP_CYCLES - 1);
    localparam logic [TW-1:0] c_enable_load  = TW'(SETTLE_CYCLES);
    localparam logic [TW-1:0] c_settle_load  = TW'(SETTLE_CYCLES + 1);
    localparam logic [TW-1:0] c_release_cnt  = TW'(2);

    state_e              state_q, state_d;
    logic [NUM_PADS-1:0] hld_q, hld_d;
    logic                init_done_q, init_done_d;
    logic                enable_q, enable_d;
    logic [IDX_W-1:0]    sel_q, sel_d;
    logic                sel_ok_q, sel_ok_d;
    pad_cfg_t            cap_q, cap_d;
    logic                shadow_wr;
    logic                tmr_load;
    logic [TW-1:0]       tmr_val;
    logic [TW-1:0]       tmr_count;
    logic                tmr_done;
    logic                cfg_xfer;
    logic                idx_ok;

    assign cfg_ready = (state_q == ST_IDLE);
    assign cfg_xfer  = cfg_valid && cfg_ready;
    assign idx_ok    = (int'(cfg_idx) < NUM_PADS);

    gpio_pad_ctrl_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (tmr_load),
        .i_load_val (tmr_val),
        .o_count    (tmr_count),
        .o_done     (tmr_done)
    );

    always_comb begin
        state_d     = state_q;
        hld_d       = hld_q;
        sel_d       = sel_q;
        sel_ok_d    = sel_ok_q;
        cap_d       = cap_q;
        shadow_wr   = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        init_done_d = init_done_q || (state_q == ST_IDLE);

        case (state_q)
            ST_PWRUP: begin
                // A zero count here can only be the first cycle after reset.
                if (tmr_done || (tmr_count == '0 && PWRUP_CYCLES == 1)) begin
                    state_d  = ST_ENABLE;
                    tmr_load = 1'b1;
                    tmr_val  = c_enable_load;
                end else if (tmr_count == '0) begin
                    tmr_load = 1'b1;
                    tmr_val  = c_pwrup_load;
                end
            end
            ST_ENABLE: begin
                if (tmr_done) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                hld_d   = '1;
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (cfg_xfer) begin
                    sel_d    = cfg_idx;
                    sel_ok_d = idx_ok;
                    cap_d    = '{dm: cfg_dm, inp_dis: cfg_inp_dis, slow: cfg_slow};
                    if (idx_ok) begin
                        hld_d[cfg_idx] = 1'b0;
                    end
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                shadow_wr = sel_ok_q;
                tmr_load  = 1'b1;
                tmr_val   = c_settle_load;
                state_d   = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (tmr_count == c_release_cnt && sel_ok_q) begin
                    hld_d[sel_q] = 1'b1;
                end
                if (tmr_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_PWRUP;
            end
        endcase

        enable_d = (state_d != ST_PWRUP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_PWRUP;
            hld_q       <= '0;
            init_done_q <= 1'b0;
            enable_q    <= 1'b0;
            sel_q       <= '0;
            sel_ok_q    <= 1'b0;
            cap_q       <= c_pad_cfg_reset;
        end else begin
            state_q     <= state_d;
            hld_q       <= hld_d;
            init_done_q <= init_done_d;
            enable_q    <= enable_d;
            sel_q       <= sel_d;
            sel_ok_q    <= sel_ok_d;
            cap_q       <= cap_d;
        end
    end

    generate
        for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
            pad_cfg_t shadow_q, shadow_d;
            logic     out_q, out_d;
            logic     oe_n_q, oe_n_d;

            // Data path follows the next hold value so it never moves while held.
            always_comb begin
                shadow_d = shadow_q;
                out_d    = out_q;
                oe_n_d   = oe_n_q;
                if (shadow_wr && sel_q == IDX_W'(i)) begin
                    shadow_d = cap_q;
                end
                if (hld_d[i]) begin
                    out_d  = core_out[i];
                    oe_n_d = init_done_q ? ~core_oe[i] : 1'b1;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    shadow_q <= c_pad_cfg_reset;
                    out_q    <= 1'b0;
                    oe_n_q   <= 1'b1;
                end else begin
                    shadow_q <= shadow_d;
                    out_q    <= out_d;
                    oe_n_q   <= oe_n_d;
                end
            end

            assign pad_out[i]         = out_q;
            assign pad_oe_n[i]        = oe_n_q;
            assign pad_dm[3*i +: 3]   = shadow_q.dm;
            assign pad_inp_dis[i]     = shadow_q.inp_dis;
            assign pad_slow[i]        = shadow_q.slow;
        end
    endgenerate

    assign pad_hld_h_n      = hld_q;
    assign init_done        = init_done_q;
    assign pad_enable_h     = enable_q;
    assign pad_enable_inp_h = enable_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_pad_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_pad_ctrl
// Brief    : Directed self-checking bench; an 8-pad and a 5-pad instance share
//            one config bus so out-of-range indices can be exercised.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_pad_ctrl;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic [2:0]  cfg_idx;
    logic [2:0]  cfg_dm;
    logic        cfg_inp_dis;
    logic        cfg_slow;
    logic [7:0]  core_out;
    logic [7:0]  core_oe;

    logic        cfg_ready, init_done, enable_h, enable_inp_h;
    logic [7:0]  pad_out, pad_oe_n, pad_inp_dis, pad_slow, pad_hld;
    logic [23:0] pad_dm;

    logic        cfg_ready5, init_done5, enable_h5, enable_inp_h5;
    logic [4:0]  pad_out5, pad_oe_n5, pad_inp_dis5, pad_slow5, pad_hld5;
    logic [14:0] pad_dm5;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    gpio_pad_ctrl #(.NUM_PADS(8), .PWRUP_CYCLES(16), .SETTLE_CYCLES(4)) u_dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_idx(cfg_idx), .cfg_dm(cfg_dm), .cfg_inp_dis(cfg_inp_dis), .cfg_slow(cfg_slow),
        .core_out(core_out), .core_oe(core_oe), .init_done(init_done),
        .pad_out(pad_out), .pad_oe_n(pad_oe_n), .pad_dm(pad_dm),
        .pad_inp_dis(pad_inp_dis), .pad_slow(pad_slow), .pad_hld_h_n(pad_hld),
        .pad_enable_h(enable_h), .pad_enable_inp_h(enable_inp_h)
    );

    gpio_pad_ctrl #(.NUM_PADS(5), .PWRUP_CYCLES(16), .SETTLE_CYCLES(4)) u_dut5 (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready5),
        .cfg_idx(cfg_idx), .cfg_dm(cfg_dm), .cfg_inp_dis(cfg_inp_dis), .cfg_slow(cfg_slow),
        .core_out(core_out[4:0]), .core_oe(core_oe[4:0]), .init_done(init_done5),
        .pad_out(pad_out5), .pad_oe_n(pad_oe_n5), .pad_dm(pad_dm5),
        .pad_inp_dis(pad_inp_dis5), .pad_slow(pad_slow5), .pad_hld_h_n(pad_hld5),
        .pad_enable_h(enable_h5), .pad_enable_inp_h(enable_inp_h5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic goto(input int k);
        while (cyc < k) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_reset_values();
        chk("rst_init_done", init_done, 0);
        chk("rst_cfg_ready", cfg_ready, 0);
        chk("rst_enable_h", enable_h, 0);
        chk("rst_enable_inp_h", enable_inp_h, 0);
        chk("rst_hld", pad_hld, 8'h00);
        chk("rst_out", pad_out, 8'h00);
        chk("rst_oe_n", pad_oe_n, 8'hFF);
        chk("rst_dm", pad_dm, 24'h249249);
        chk("rst_inp_dis", pad_inp_dis, 8'hFF);
        chk("rst_slow", pad_slow, 8'h00);
        chk("rst_hld5", pad_hld5, 5'h00);
        chk("rst_dm5", pad_dm5, 15'h1249);
    endtask

    // Expects reset released at cycle 0 with core_oe all ones.
    task automatic powerup_seq(input logic [7:0] exp_out);
        goto(15);
        chk("pu_enable_h_c15", enable_h, 0);
        goto(16);
        chk("pu_enable_h_c16", enable_h, 1);
        chk("pu_enable_inp_h_c16", enable_inp_h, 1);
        chk("pu_oe_n_pre_init", pad_oe_n, 8'hFF);
        goto(20);
        chk("pu_hld_c20", pad_hld, 8'h00);
        chk("pu_ready_c20", cfg_ready, 0);
        goto(21);
        chk("pu_hld_c21", pad_hld, 8'hFF);
        chk("pu_hld5_c21", pad_hld5, 5'h1F);
        chk("pu_init_c21", init_done, 0);
        chk("pu_ready_c21", cfg_ready, 1);
        chk("pu_out_c21", pad_out, exp_out);
        chk("pu_oe_n_c21", pad_oe_n, 8'hFF);
        goto(22);
        chk("pu_init_c22", init_done, 1);
        chk("pu_init5_c22", init_done5, 1);
        chk("pu_oe_n_c22", pad_oe_n, 8'hFF);
        goto(23);
        chk("pu_oe_n_c23", pad_oe_n, 8'h00);
        chk("pu_oe_n5_c23", pad_oe_n5, 5'h00);
    endtask

    initial begin
        rst         = 1'b1;
        cfg_valid   = 1'b0;
        cfg_idx     = 3'd0;
        cfg_dm      = 3'd0;
        cfg_inp_dis = 1'b0;
        cfg_slow    = 1'b0;
        core_out    = 8'hA5;
        core_oe     = 8'hFF;
        repeat (3) @(negedge clk);
        check_reset_values();

        rst = 1'b0;
        cyc = 0;
        powerup_seq(8'hA5);

        // Config write to pad 3 while toggling core data during its hold.
        goto(24);
        cfg_valid = 1'b1; cfg_idx = 3'd3; cfg_dm = 3'b110; cfg_inp_dis = 1'b0; cfg_slow = 1'b1;
        goto(25);
        chk("wr3_hld_c1", pad_hld, 8'hF7);
        chk("wr3_ready_c1", cfg_ready, 0);
        cfg_valid = 1'b0;
        core_out  = 8'hAD;
        core_oe   = 8'h00;
        goto(26);
        chk("wr3_hld_c2", pad_hld, 8'hF7);
        chk("wr3_out_frozen_c2", pad_out, 8'hA5);
        chk("wr3_oe_n_frozen_c2", pad_oe_n, 8'hF7);
        chk("wr3_dm_c2", pad_dm, 24'h249C49);
        goto(29);
        chk("wr3_hld_c5", pad_hld, 8'hF7);
        chk("wr3_out_frozen_c5", pad_out, 8'hA5);
        chk("wr3_ready_c5", cfg_ready, 0);
        goto(30);
        chk("wr3_hld_c6", pad_hld, 8'hFF);
        chk("wr3_out_c6", pad_out, 8'hAD);
        chk("wr3_oe_n_c6", pad_oe_n, 8'hFF);
        chk("wr3_ready_c6", cfg_ready, 0);
        goto(31);
        chk("wr3_ready_c7", cfg_ready, 1);
        chk("wr3_dm_c7", pad_dm, 24'h249C49);
        chk("wr3_inp_dis", pad_inp_dis, 8'hF7);
        chk("wr3_slow", pad_slow, 8'h08);
        core_oe = 8'hFF;

        // idx 6: valid on the 8-pad instance, out of range on the 5-pad one.
        // cfg_valid is held through the busy window and must not re-trigger.
        goto(32);
        chk("wr6_oe_n_restored", pad_oe_n, 8'h00);
        cfg_valid = 1'b1; cfg_idx = 3'd6; cfg_dm = 3'b111; cfg_inp_dis = 1'b0; cfg_slow = 1'b1;
        goto(33);
        chk("wr6_hld_c1", pad_hld, 8'hBF);
        chk("oor_hld5_c1", pad_hld5, 5'h1F);
        chk("oor_ready5_c1", cfg_ready5, 0);
        goto(38);
        chk("oor_hld5_c6", pad_hld5, 5'h1F);
        chk("oor_ready5_c6", cfg_ready5, 0);
        chk("wr6_ready_c6", cfg_ready, 0);
        cfg_valid = 1'b0;
        goto(39);
        chk("oor_ready5_c7", cfg_ready5, 1);
        chk("oor_dm5", pad_dm5, 15'h1C49);
        chk("oor_inp_dis5", pad_inp_dis5, 5'h17);
        chk("oor_slow5", pad_slow5, 5'h08);
        chk("wr6_dm", pad_dm, 24'h3C9C49);
        chk("wr6_inp_dis", pad_inp_dis, 8'hB7);
        chk("wr6_slow", pad_slow, 8'h48);
        goto(40);
        chk("noqueue_ready", cfg_ready, 1);

        // Reset asserted mid-SETTLE, then the full power-up repeats.
        goto(41);
        cfg_valid = 1'b1; cfg_idx = 3'd1; cfg_dm = 3'b010; cfg_inp_dis = 1'b1; cfg_slow = 1'b0;
        goto(42);
        cfg_valid = 1'b0;
        goto(44);
        chk("settle_hld_before_rst", pad_hld, 8'hFD);
        rst = 1'b1;
        #1;
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        powerup_seq(8'hAD);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
